// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared opcode constants, instruction field positions and the
//                FSM state type for the control unit and its register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

    // Opcode map: 0000 loads an immediate, 1111 is a no-op, everything in
    // between is forwarded to the external ALU unchanged.
    localparam logic [3:0] c_OP_LDI     = 4'h0;
    localparam logic [3:0] c_OP_ALU_MIN = 4'h1;
    localparam logic [3:0] c_OP_ALU_MAX = 4'hE;
    localparam logic [3:0] c_OP_NOP     = 4'hF;

    // Instruction field positions (imm overlaps rb and the unused low bits).
    localparam int c_OP_MSB  = 11;
    localparam int c_OP_LSB  = 8;
    localparam int c_RD_MSB  = 7;
    localparam int c_RD_LSB  = 6;
    localparam int c_RA_MSB  = 5;
    localparam int c_RA_LSB  = 4;
    localparam int c_RB_MSB  = 3;
    localparam int c_RB_LSB  = 2;
    localparam int c_IMM_MSB = 3;
    localparam int c_IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } cu_state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= c_OP_ALU_MIN) && (op <= c_OP_ALU_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Instruction handshake, ALU issue/return and writeback bus of
//                the control unit.
//                slave  : seen by control_unit (accepts instructions, drives
//                         ALU operands, writeback and flags)
//                master : seen by the instruction source / ALU side
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if;
    logic        instr_valid;
    logic [11:0] instr;
    logic        instr_ready;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_op;
    logic [3:0]  alu_result;
    logic [4:0]  alu_status;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [3:0]  wb_data;
    logic [4:0]  flags;

    modport slave (
        input  instr_valid, instr, alu_result, alu_status,
        output instr_ready, alu_a, alu_b, alu_op,
               wb_valid, wb_addr, wb_data, flags
    );

    modport master (
        output instr_valid, instr, alu_result, alu_status,
        input  instr_ready, alu_a, alu_b, alu_op,
               wb_valid, wb_addr, wb_data, flags
    );
endinterface
`default_nettype wire

// File: rtl/cu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : cu_regfile
//  Description : 4 x 4-bit register file, two combinational read ports and
//                one synchronous write port, synchronous reset to zero.
//  Ports       : clk, rst                  clock / sync active-high reset
//                i_ra_addr -> o_ra_data    read port A
//                i_rb_addr -> o_rb_data    read port B
//                i_we, i_wr_addr, i_wr_data write port
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_regfile (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_ra_addr,
    output logic [3:0]      o_ra_data,
    input  wire logic [1:0] i_rb_addr,
    output logic [3:0]      o_rb_data,
    input  wire logic       i_we,
    input  wire logic [1:0] i_wr_addr,
    input  wire logic [3:0] i_wr_data
);

    logic [3:0] r_mem [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Sequencer for a 4-register machine. Accepts one instruction
//                at a time, issues ALU ops to an external ALU, waits ALU_LAT
//                cycles and writes the result back; LDI writes an immediate.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                bus        control_unit_if.slave (instruction handshake,
//                           ALU operands/result, writeback, flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import cu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    control_unit_if.slave bus
);

    localparam logic [2:0] c_WAIT_INIT = 3'(ALU_LAT - 1);

    cu_state_t  r_state;
    cu_state_t  w_state_nxt;
    logic [2:0] r_wait_cnt;
    logic [1:0] r_rd;
    logic [3:0] r_imm;
    logic       r_is_ldi;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [3:0] r_alu_op;
    logic       r_wb_valid;
    logic [1:0] r_wb_addr;
    logic [3:0] r_wb_data;
    logic [4:0] r_flags;

    logic [3:0] w_op;
    logic [1:0] w_rd;
    logic [3:0] w_ra_data;
    logic [3:0] w_rb_data;
    logic       w_accept;
    logic       w_wb_we;
    logic [3:0] w_wb_data;

    assign w_op     = bus.instr[c_OP_MSB:c_OP_LSB];
    assign w_rd     = bus.instr[c_RD_MSB:c_RD_LSB];
    assign w_accept = (r_state == S_IDLE) && bus.instr_valid;
    assign w_wb_we  = (r_state == S_WB);
    assign w_wb_data = r_is_ldi ? r_imm : bus.alu_result;

    // The write lands on the WB->IDLE edge and reads are combinational, so an
    // instruction accepted in the following IDLE cycle sees the new value.
    cu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ra_addr (bus.instr[c_RA_MSB:c_RA_LSB]),
        .o_ra_data (w_ra_data),
        .i_rb_addr (bus.instr[c_RB_MSB:c_RB_LSB]),
        .o_rb_data (w_rb_data),
        .i_we      (w_wb_we),
        .i_wr_addr (r_rd),
        .i_wr_data (w_wb_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    if (w_op == c_OP_LDI) begin
                        w_state_nxt = S_WB;
                    end else if (is_alu_op(w_op)) begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_is_ldi   <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_flags    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wb_valid <= 1'b0;

            if (w_accept && (w_op == c_OP_LDI)) begin
                r_rd     <= w_rd;
                r_imm    <= bus.instr[c_IMM_MSB:c_IMM_LSB];
                r_is_ldi <= 1'b1;
            end else if (w_accept && is_alu_op(w_op)) begin
                // Operands stay on alu_* until the next accepted ALU op.
                r_rd     <= w_rd;
                r_is_ldi <= 1'b0;
                r_alu_a  <= w_ra_data;
                r_alu_b  <= w_rb_data;
                r_alu_op <= w_op;
            end

            if (r_state == S_ISSUE) begin
                r_wait_cnt <= c_WAIT_INIT;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end

            if (r_state == S_WB) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= r_rd;
                r_wb_data  <= w_wb_data;
                if (!r_is_ldi) begin
                    r_flags <= bus.alu_status;
                end
            end
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_addr     = r_wb_addr;
    assign bus.wb_data     = r_wb_data;
    assign bus.flags       = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Bench for control_unit. Two instances (ALU_LAT=1 and 3), each
//                with a registered ALU model, directed scenarios with literal
//                expectations and randomized traffic against a transaction-
//                level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_v    [2];
    logic        valid_v  [2];
    logic [11:0] instr_v  [2];
    logic        ready_v  [2];
    logic        wbv_v    [2];
    logic [1:0]  wba_v    [2];
    logic [3:0]  wbd_v    [2];
    logic [3:0]  a_v      [2];
    logic [3:0]  b_v      [2];
    logic [3:0]  op_v     [2];
    logic [4:0]  flags_v  [2];

    // ALU behaviour: returns {P,Z,C,S,O, result}.
    function automatic logic [8:0] alu_fn(input logic [3:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        logic [4:0] sum;
        logic [3:0] res;
        logic       c;
        logic       o;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'h1: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[3:0];
                c   = sum[4];
                o   = (a[3] == b[3]) && (res[3] != a[3]);
            end
            4'h2: begin
                res = a - b;
                c   = (a < b);
                o   = (a[3] != b[3]) && (res[3] != a[3]);
            end
            4'h3:    res = a & b;
            4'h4:    res = a | b;
            4'h5:    res = a ^ b;
            default: res = {a[2:0], a[3]} ^ b ^ op;
        endcase
        return {^res, (res == 4'h0), c, res[3], o, res};
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            control_unit_if u_if ();

            assign u_if.instr_valid = valid_v[g];
            assign u_if.instr       = instr_v[g];
            assign ready_v[g]       = u_if.instr_ready;
            assign wbv_v[g]         = u_if.wb_valid;
            assign wba_v[g]         = u_if.wb_addr;
            assign wbd_v[g]         = u_if.wb_data;
            assign a_v[g]           = u_if.alu_a;
            assign b_v[g]           = u_if.alu_b;
            assign op_v[g]          = u_if.alu_op;
            assign flags_v[g]       = u_if.flags;

            always @(posedge clk) begin
                {u_if.alu_status, u_if.alu_result} <= alu_fn(u_if.alu_op, u_if.alu_a, u_if.alu_b);
            end

            control_unit #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
                .clk (clk),
                .rst (rst_v[g]),
                .bus (u_if.slave)
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reference model: a busy counter of cycles until the writeback edge.
    // ------------------------------------------------------------------
    int         m_pend  [2];
    bit         m_live  [2];
    logic [3:0] m_regs  [2][4];
    logic [3:0] m_a     [2];
    logic [3:0] m_b     [2];
    logic [3:0] m_op    [2];
    logic       m_wbv   [2];
    logic [1:0] m_wba   [2];
    logic [3:0] m_wbd   [2];
    logic [4:0] m_flags [2];
    logic [1:0] m_rd    [2];
    logic [3:0] m_imm   [2];
    bit         m_ldi   [2];
    bit         m_acc;
    logic [3:0] m_iop;
    logic [8:0] m_fn;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_v[k]) begin
                m_live[k]  = 1'b1;
                m_pend[k]  = 0;
                for (int r = 0; r < 4; r++) m_regs[k][r] = 4'h0;
                m_a[k]     = 4'h0;
                m_b[k]     = 4'h0;
                m_op[k]    = 4'h0;
                m_wbv[k]   = 1'b0;
                m_wba[k]   = 2'h0;
                m_wbd[k]   = 4'h0;
                m_flags[k] = 5'h0;
            end else begin
                m_acc    = valid_v[k] && (m_pend[k] == 0);
                m_wbv[k] = 1'b0;
                if (m_pend[k] > 0) begin
                    m_pend[k]--;
                    if (m_pend[k] == 0) begin
                        if (m_ldi[k]) begin
                            m_wbd[k] = m_imm[k];
                        end else begin
                            m_fn       = alu_fn(m_op[k], m_a[k], m_b[k]);
                            m_wbd[k]   = m_fn[3:0];
                            m_flags[k] = m_fn[8:4];
                        end
                        m_wba[k]              = m_rd[k];
                        m_regs[k][m_rd[k]]    = m_wbd[k];
                        m_wbv[k]              = 1'b1;
                    end
                end
                if (m_acc) begin
                    m_iop = instr_v[k][11:8];
                    if (m_iop == 4'h0) begin
                        m_pend[k] = 1;
                        m_ldi[k]  = 1'b1;
                        m_rd[k]   = instr_v[k][7:6];
                        m_imm[k]  = instr_v[k][3:0];
                    end else if (m_iop != 4'hF) begin
                        m_a[k]    = m_regs[k][instr_v[k][5:4]];
                        m_b[k]    = m_regs[k][instr_v[k][3:2]];
                        m_op[k]   = m_iop;
                        m_pend[k] = 2 + ((k == 0) ? 1 : 3);
                        m_ldi[k]  = 1'b0;
                        m_rd[k]   = instr_v[k][7:6];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_live[k]) begin
                chk("ready",   k, 8'(ready_v[k]), 8'(m_pend[k] == 0));
                chk("wb_valid", k, 8'(wbv_v[k]),  8'(m_wbv[k]));
                chk("wb_addr", k, 8'(wba_v[k]),   8'(m_wba[k]));
                chk("wb_data", k, 8'(wbd_v[k]),   8'(m_wbd[k]));
                chk("alu_a",   k, 8'(a_v[k]),     8'(m_a[k]));
                chk("alu_b",   k, 8'(b_v[k]),     8'(m_b[k]));
                chk("alu_op",  k, 8'(op_v[k]),    8'(m_op[k]));
                chk("flags",   k, 8'(flags_v[k]), 8'(m_flags[k]));
            end
        end
    end

    int ncyc = 0;
    int q0[$];
    always @(negedge clk) begin
        ncyc++;
        if (wbv_v[0]) q0.push_back(ncyc);
    end

    // Called just after a negedge; returns just after the negedge following
    // the accept edge. waited = cycles spent waiting for ready.
    task automatic send(input int k, input logic [11:0] ins, input bit hold, output int waited);
        int n = 0;
        valid_v[k] = 1'b1;
        instr_v[k] = ins;
        while (!ready_v[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ready_v[k]) begin
            errors++;
            $display("FAIL send_timeout[%0d] got ready=0 expected ready=1", k);
        end
        @(negedge clk);
        if (!hold) valid_v[k] = 1'b0;
        waited = n;
    endtask

    task automatic wait_wb(input int k, output int n);
        n = 0;
        while (!wbv_v[k] && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {4'h0, rd, 2'b00, imm};
    endfunction

    function automatic logic [11:0] alu(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 2'b00};
    endfunction

    task automatic rand_run(input int k, input int count);
        int w;
        logic [3:0] op;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_v[k] = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst_v[k] = 1'b0;
            end else begin
                case ($urandom_range(0, 3))
                    0:       op = 4'h0;
                    1:       op = 4'hF;
                    default: op = 4'($urandom_range(1, 14));
                endcase
                send(k, {op, 8'($urandom)}, bit'($urandom_range(0, 1)), w);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                valid_v[k] = 1'b0;
            end
        end
    endtask

    int n;
    int w;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k]   = 1'b1;
            valid_v[k] = 1'b0;
            instr_v[k] = 12'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b0;
            chk("rst_ready", k, 8'(ready_v[k]), 8'h1);
            chk("rst_wbv",   k, 8'(wbv_v[k]),   8'h0);
            chk("rst_op",    k, 8'(op_v[k]),    8'h0);
            chk("rst_flags", k, 8'(flags_v[k]), 8'h0);
        end

        // LDI r0=5, LDI r1=3, ADD r2=r0+r1
        send(0, ldi(2'd0, 4'd5), 1'b0, w);
        wait_wb(0, n);
        chk("ldi_lat", 0, 8'(n), 8'd1);
        send(0, ldi(2'd1, 4'd3), 1'b0, w);
        wait_wb(0, n);
        send(0, alu(4'h1, 2'd2, 2'd0, 2'd1), 1'b0, w);
        wait_wb(0, n);
        chk("add_lat",   0, 8'(n),          8'd3);
        chk("add_addr",  0, 8'(wba_v[0]),   8'd2);
        chk("add_data",  0, 8'(wbd_v[0]),   8'd8);
        chk("add_flags", 0, 8'(flags_v[0]), 8'b10011);

        // SUB r3 = r1 - r0 = 3 - 5
        send(0, alu(4'h2, 2'd3, 2'd1, 2'd0), 1'b0, w);
        wait_wb(0, n);
        chk("sub_data",  0, 8'(wbd_v[0]),    8'b1110);
        chk("sub_carry", 0, 8'(flags_v[0][2]), 8'h1);

        // Three ALU ops with instr_valid held high throughout
        @(negedge clk);
        q0.delete();
        send(0, alu(4'h3, 2'd0, 2'd2, 2'd3), 1'b1, w);
        send(0, alu(4'h4, 2'd1, 2'd2, 2'd3), 1'b1, w);
        send(0, alu(4'h5, 2'd2, 2'd2, 2'd3), 1'b1, w);
        valid_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_count", 0, 8'(q0.size()), 8'd3);
        if (q0.size() == 3) begin
            chk("b2b_gap1", 0, 8'(q0[1] - q0[0]), 8'd4);
            chk("b2b_gap2", 0, 8'(q0[2] - q0[1]), 8'd4);
        end

        // Reset during WAIT aborts the op
        q0.delete();
        send(0, alu(4'h1, 2'd1, 2'd2, 2'd3), 1'b0, w);
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("abort_op", 0, 8'(op_v[0]), 8'h0);
        @(negedge clk);
        chk("abort_ready", 0, 8'(ready_v[0]), 8'h1);
        repeat (4) @(negedge clk);
        chk("abort_no_wb", 0, 8'(q0.size()), 8'd0);
        send(0, alu(4'h1, 2'd0, 2'd2, 2'd3), 1'b0, w);
        chk("abort_a", 0, 8'(a_v[0]), 8'h0);
        chk("abort_b", 0, 8'(b_v[0]), 8'h0);
        wait_wb(0, n);
        chk("zero_add", 0, 8'(wbd_v[0]), 8'h0);

        // NOP between two LDIs
        @(negedge clk);
        q0.delete();
        send(0, ldi(2'd1, 4'd9), 1'b0, w);
        wait_wb(0, n);
        send(0, {4'hF, 8'h00}, 1'b0, w);
        send(0, ldi(2'd2, 4'd6), 1'b0, w);
        chk("nop_next", 0, 8'(w), 8'd0);
        repeat (3) @(negedge clk);
        chk("nop_wbs",   0, 8'(q0.size()),  8'd2);
        chk("nop_flags", 0, 8'(flags_v[0]), 8'b01000);

        // ALU_LAT=3 instance: ADD r0 = r0 + r0 with r0 = 7
        send(1, ldi(2'd0, 4'd7), 1'b0, w);
        wait_wb(1, n);
        send(1, alu(4'h1, 2'd0, 2'd0, 2'd0), 1'b0, w);
        wait_wb(1, n);
        chk("lat3_lat",  1, 8'(n),        8'd5);
        chk("lat3_data", 1, 8'(wbd_v[1]), 8'b1110);

        // Randomized traffic on both instances
        fork
            rand_run(0, 250);
            rand_run(1, 150);
        join
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, number of WAIT cycles between ALU issue and writeback (1..7).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr  input  12  fields: [11:8] op, [7:6] rd, [5:4] ra, [3:2] rb, [3:0] imm (LDI only).
REQ-006 SHALL have port instr_ready  output  1  instruction accepted when valid and ready are both high at a clock edge.
REQ-007 SHALL have port alu_a  output  4  ALU operand A.
REQ-008 SHALL have port alu_b  output  4  ALU operand B.
REQ-009 SHALL have port alu_op  output  4  ALU opcode, using the ALU encoding 0001..1110.
REQ-010 SHALL have port alu_result  input  4  registered ALU result.
REQ-011 SHALL have port alu_status  input  5  registered ALU flags [P,Z,C,S,O].
REQ-012 SHALL have port wb_valid  output  1  one-cycle writeback pulse.
REQ-013 SHALL have port wb_addr  output  2  destination register of the writeback.
REQ-014 SHALL have port wb_data  output  4  value written.
REQ-015 SHALL have port flags  output  5  last captured ALU status [P,Z,C,S,O].

Function
REQ-016 SHALL hold four 4-bit registers r0..r3.
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, WB, with instr_ready high only in IDLE.
REQ-018 SHALL, on an accepted op 0001..1110: go IDLE->ISSUE, and register alu_a=r[ra], alu_b=r[rb], alu_op=op on the accept edge.
REQ-019 SHALL keep alu_a, alu_b and alu_op stable from issue until the next accepted ALU op.
REQ-020 SHALL go ISSUE->WAIT after 1 cycle, and WAIT->WB after ALU_LAT cycles.
REQ-021 SHALL, in WB: write alu_result to r[rd], load flags from alu_status, assert wb_valid with wb_addr=rd and wb_data=alu_result, then return to IDLE.
REQ-022 SHALL give ALU op latency from accept edge to wb_valid of 2+ALU_LAT cycles, and ALU op throughput of one instruction per 3+ALU_LAT cycles.
REQ-023 SHALL, on op 0000 (LDI): go IDLE->WB, write imm to r[rd], pulse wb_valid with wb_data=imm, and leave flags and alu_* unchanged.
REQ-024 SHALL, on op 1111 (NOP): accept the instruction, stay in IDLE, and produce no writeback and no change to alu_* or flags.
REQ-025 SHALL ignore instr_valid while not in IDLE, leaving the instruction pending for the source to hold.
REQ-026 SHALL let an instruction accepted on the cycle after WB read the value just written (write-before-read ordering, no stale operand).
REQ-027 SHALL keep wb_data/wb_addr equal to the last writeback values when wb_valid is low.

Reset
REQ-028 SHALL, with rst high at a clock edge, set state=IDLE, r0..r3=0, alu_a=alu_b=0, alu_op=0000, flags=0, wb_valid=0, wb_addr=0, wb_data=0.
REQ-029 SHALL let rst asserted in ISSUE/WAIT/WB abort the operation: no wb_valid pulse, no register write, instr_ready high on the first cycle after rst deasserts.
REQ-030 SHALL let rst take priority over any simultaneous handshake.

Structure
REQ-031 SHALL place the opcode constants (LDI, ALU op range, NOP), instr field positions, and the state enum in shared package cu_pkg.
REQ-032 SHALL implement the register file as sub-module cu_regfile: 4x4 bits, two combinational read ports, one synchronous write port, synchronous reset to zero.
REQ-033 SHALL contain no arithmetic itself, with all ALU operations executed externally.

Verification
REQ-034 SHALL run: LDI r0=5, LDI r1=3, ADD (0001) rd=r2 ra=r0 rb=r1 against an ALU model -> wb_valid 3 cycles after accept, wb_addr=2, wb_data=8, flags=alu_status.
REQ-035 SHALL run: SUB (0010) r3=r1-r0 with r1=3, r0=5 -> wb_data=1110, model-reported carry copied to flags[2].
REQ-036 SHALL run: instr_valid held high continuously with 3 ALU ops -> instr_ready high only in IDLE, exactly 3 wb_valid pulses 4 cycles apart (ALU_LAT=1).
REQ-037 SHALL run: rst asserted during WAIT -> no wb_valid, r0..r3=0, alu_op=0000, instr_ready=1 one cycle after rst falls.
REQ-038 SHALL run: NOP between two LDIs -> no wb_valid for the NOP, flags unchanged, second LDI accepted the next cycle.
REQ-039 SHALL run: ALU_LAT=3, ADD r0=r0+r0 with r0=7 -> wb_valid 5 cycles after accept, wb_data=1110.
